// File: rtl/axil_pkg.sv
// Types and constants shared by the two-client AXI4-Lite master.
package axil_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WB,
        ST_RA,
        ST_RD,
        ST_DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; the pointer holds the last granted client.
// A lone requester always wins. The pointer advances only when update is high.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant_idx,
    output logic       grant_valid
);

    logic last;

    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_idx = ~last;
        end else begin
            grant_idx = req[1];
        end
    end

    // Reset value 1 makes client 0 the winner of the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (update && grant_valid) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/axil_master_arbiter.sv
// Shares one AXI4-Lite slave between two clients: round-robin grant, one transaction in flight.
// Ack arrives three cycles after req with a zero-wait slave; every AXI valid is held until its handshake.
module axil_master_arbiter
    import axil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [1:0]            req,
    input  logic [1:0]            we,
    input  logic [2*ADDR_W-1:0]   addr,
    input  logic [2*DATA_W-1:0]   wdata,
    output logic [1:0]            ack,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            resp,
    output logic                  busy,
    output logic [ADDR_W-1:0]     M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_W-1:0]     M_AXI_WDATA,
    output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    output logic [ADDR_W-1:0]     M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_W-1:0]     M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic [1:0]          ack_q, ack_d, resp_q, resp_d;
    logic                busy_q, busy_d;
    logic                grant_idx, grant_valid, arb_update;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_arbiter2 u_arb (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .req         (req),
        .update      (arb_update),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign sel_addr  = grant_idx ? addr[2*ADDR_W-1:ADDR_W]  : addr[ADDR_W-1:0];
    assign sel_wdata = grant_idx ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        awaddr_d   = awaddr_q;
        araddr_d   = araddr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        resp_d     = resp_q;
        busy_d     = busy_q;
        ack_d      = 2'b00;
        arb_update = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    arb_update = 1'b1;
                    gnt_d      = grant_idx;
                    busy_d     = 1'b1;
                    if (we[grant_idx]) begin
                        state_d   = ST_WR;
                        awaddr_d  = sel_addr;
                        wdata_d   = sel_wdata;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = ST_RA;
                        araddr_d  = sel_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end
            ST_WR: begin
                // AW and W complete independently; leave once neither is still pending.
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
                    state_d  = ST_WB;
                    bready_d = 1'b1;
                end
            end
            ST_WB: begin
                if (M_AXI_BVALID) begin
                    bready_d     = 1'b0;
                    resp_d       = M_AXI_BRESP;
                    rdata_d      = '0;
                    ack_d[gnt_q] = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_RA: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD;
                end
            end
            ST_RD: begin
                if (M_AXI_RVALID) begin
                    rready_d     = 1'b0;
                    rdata_d      = M_AXI_RDATA;
                    resp_d       = M_AXI_RRESP;
                    ack_d[gnt_q] = 1'b1;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                rdata_d = '0;
                resp_d  = RESP_OKAY;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            resp_q    <= '0;
            busy_q    <= 1'b0;
            ack_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            resp_q    <= resp_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
        end
    end

    assign ack           = ack_q;
    assign rdata         = rdata_q;
    assign resp          = resp_q;
    assign busy          = busy_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = PROT_DEFAULT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = PROT_DEFAULT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Bench: two client drivers, a delay-programmable slave, and a transaction-level model checked every cycle.
module tb_axil_master_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    logic [1:0] req = '0, we = '0;
    logic [2*AW-1:0] addr = '0;
    logic [2*DW-1:0] wdata = '0;
    logic [1:0] ack, resp;
    logic [DW-1:0] rdata;
    logic busy;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0] AWPROT, ARPROT;
    logic AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic [DW-1:0] WDATA;
    logic [DW/8-1:0] WSTRB;
    logic AWREADY = 0, WREADY = 0, BVALID = 0, ARREADY = 0, RVALID = 0;
    logic [1:0] BRESP = 0, RRESP = 0;
    logic [DW-1:0] RDATA = 0;

    axil_master_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .resp(resp), .busy(busy),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed { logic w; logic [31:0] a; logic [31:0] d; } txn_t;
    txn_t q0[$], q1[$];
    int gap [2] = '{0, 0};
    int req_cyc [2] = '{0, 0};
    bit gap_en = 0;

    task automatic push(input int c, input logic w, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.w = w; t.a = a; t.d = d;
        if (c == 0) q0.push_back(t); else q1.push_back(t);
    endtask

    // Client drivers: hold a request until its ack, then load the next queued one.
    initial begin
        txn_t t;
        bit have;
        forever begin
            @(posedge ACLK); #1;
            if (!ARESETN) begin req = 2'b00; gap = '{0, 0}; continue; end
            for (int i = 0; i < 2; i++) begin
                if (ack[i] && req[i]) begin
                    req[i] = 1'b0;
                    gap[i] = gap_en ? int'($urandom_range(0, 2)) : 0;
                end
                if (!req[i]) begin
                    have = 0;
                    if (gap[i] > 0) gap[i]--;
                    else if (i == 0 && q0.size() > 0) begin t = q0.pop_front(); have = 1; end
                    else if (i == 1 && q1.size() > 0) begin t = q1.pop_front(); have = 1; end
                    if (have) begin
                        req[i] = 1'b1; we[i] = t.w;
                        addr[i*AW +: AW] = t.a; wdata[i*DW +: DW] = t.d;
                        req_cyc[i] = cyc;
                    end
                end
            end
        end
    end

    // Slave: register bank with programmable ready/response delays and error injection.
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit s_err = 0, r_hold = 0;
    logic [31:0] s_mem [16];
    initial begin
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs, awv_p, wv_p, arv_p, got_aw, got_w, got_ar;
        int aw_w, w_w, b_w, ar_w, r_w;
        logic [31:0] s_awaddr, s_wdata, s_araddr;
        for (int i = 0; i < 16; i++) s_mem[i] = '0;
        {got_aw, got_w, got_ar} = '0;
        {aw_w, w_w, b_w, ar_w, r_w} = '0;
        s_awaddr = '0; s_wdata = '0; s_araddr = '0;
        forever begin
            @(negedge ACLK);
            aw_hs = AWVALID && AWREADY; w_hs = WVALID && WREADY; b_hs = BVALID && BREADY;
            ar_hs = ARVALID && ARREADY; r_hs = RVALID && RREADY;
            if (aw_hs) s_awaddr = AWADDR;
            if (w_hs)  s_wdata  = WDATA;
            if (ar_hs) s_araddr = ARADDR;
            awv_p = AWVALID; wv_p = WVALID; arv_p = ARVALID;
            @(posedge ACLK); #1;
            if (!ARESETN) begin
                {AWREADY, WREADY, BVALID, ARREADY, RVALID} = '0;
                {got_aw, got_w, got_ar} = '0;
                {aw_w, w_w, b_w, ar_w, r_w} = '0;
                continue;
            end
            if (aw_hs) begin got_aw = 1; aw_w = 0; end else if (awv_p) aw_w++;
            if (w_hs)  begin got_w = 1;  w_w = 0;  end else if (wv_p)  w_w++;
            AWREADY = AWVALID && (aw_w >= aw_dly);
            WREADY  = WVALID && (w_w >= w_dly);
            if (b_hs) begin BVALID = 0; got_aw = 0; got_w = 0; b_w = 0; end
            else if (got_aw && got_w && !BVALID) begin
                if (b_w >= b_dly) begin
                    BVALID = 1; BRESP = s_err ? 2'b10 : 2'b00;
                    if (!s_err) s_mem[s_awaddr[5:2]] = s_wdata;
                end else b_w++;
            end
            if (ar_hs) begin got_ar = 1; ar_w = 0; r_w = 0; end else if (arv_p) ar_w++;
            ARREADY = ARVALID && (ar_w >= ar_dly);
            if (r_hs) begin RVALID = 0; got_ar = 0; end
            else if (got_ar && !RVALID && !r_hold) begin
                if (r_w >= r_dly) begin
                    RVALID = 1; RDATA = s_mem[s_araddr[5:2]]; RRESP = s_err ? 2'b10 : 2'b00;
                end else r_w++;
            end
        end
    end

    // Transaction-level model: phase 0 idle, 1 in flight, 2 acking.
    int m_phase = 0, m_cli = 0, m_last = 1;
    bit m_we, aw_seen, w_seen, ar_seen;
    logic [31:0] m_addr, m_data, exp_rdata = 0;
    logic [1:0] exp_ack = 0, exp_resp = 0;
    logic exp_busy = 0;
    logic [31:0] mem_ref [16];
    int awv_cnt = 0, wv_cnt = 0;
    int alog_cli[$], alog_cyc[$];
    logic [31:0] alog_rdata[$];
    logic [1:0] alog_resp[$];
    initial for (int i = 0; i < 16; i++) mem_ref[i] = '0;

    always @(negedge ACLK) begin
        if (!ARESETN) begin
            m_phase = 0; m_last = 1; exp_ack = 0; exp_busy = 0; exp_rdata = 0; exp_resp = 0;
            check("reset_outputs", {ack, busy, resp, rdata, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 64'd0);
            check("reset_addr_data", {AWADDR, ARADDR}, 64'd0);
        end else begin
            check("ack", ack, exp_ack);
            check("busy", busy, exp_busy);
            check("rdata", rdata, exp_rdata);
            check("resp", resp, exp_resp);
            check("prot_strb", {AWPROT, ARPROT, WSTRB}, {3'b000, 3'b000, 4'hF});
            if (ack != 0) begin
                alog_cli.push_back(ack[1] ? 1 : 0); alog_cyc.push_back(cyc);
                alog_rdata.push_back(rdata); alog_resp.push_back(resp);
            end
            if (AWVALID) awv_cnt++;
            if (WVALID) wv_cnt++;
            if (m_phase != 1)
                check("axi_quiet", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 64'd0);
            else if (m_we) begin
                check("write_channels", {AWVALID, WVALID, BREADY, ARVALID, RREADY},
                      {!aw_seen, !w_seen, aw_seen && w_seen, 1'b0, 1'b0});
                if (AWVALID && AWREADY) check("awaddr", AWADDR, m_addr);
                if (WVALID && WREADY) check("wdata", WDATA, m_data);
            end else begin
                check("read_channels", {AWVALID, WVALID, BREADY, ARVALID, RREADY},
                      {3'b000, !ar_seen, ar_seen});
                if (ARVALID && ARREADY) check("araddr", ARADDR, m_addr);
            end
            case (m_phase)
                0: begin
                    exp_ack = 0; exp_rdata = 0; exp_resp = 0; exp_busy = 0;
                    if (req != 2'b00) begin
                        m_cli = (req == 2'b11) ? (1 - m_last) : (req[1] ? 1 : 0);
                        m_last = m_cli;
                        m_we = we[m_cli]; m_addr = addr[m_cli*AW +: AW]; m_data = wdata[m_cli*DW +: DW];
                        aw_seen = 0; w_seen = 0; ar_seen = 0;
                        m_phase = 1; exp_busy = 1;
                    end
                end
                1: begin
                    if (m_we) begin
                        if (AWVALID && AWREADY) aw_seen = 1;
                        if (WVALID && WREADY) w_seen = 1;
                        if (BVALID && BREADY) begin
                            m_phase = 2; exp_ack = 2'b01 << m_cli; exp_rdata = 0;
                            exp_resp = s_err ? 2'b10 : 2'b00;
                            if (!s_err) mem_ref[m_addr[5:2]] = m_data;
                        end
                    end else begin
                        if (ARVALID && ARREADY) ar_seen = 1;
                        if (RVALID && RREADY) begin
                            m_phase = 2; exp_ack = 2'b01 << m_cli;
                            exp_rdata = mem_ref[m_addr[5:2]];
                            exp_resp = s_err ? 2'b10 : 2'b00;
                        end
                    end
                end
                default: begin
                    m_phase = 0; exp_ack = 0; exp_busy = 0; exp_rdata = 0; exp_resp = 0;
                end
            endcase
        end
    end

    task automatic wait_done(input string name);
        int n;
        n = 0;
        repeat (2) @(posedge ACLK);
        #2;
        while (!(q0.size() == 0 && q1.size() == 0 && req == 2'b00 && m_phase == 0) && n < 3000) begin
            @(posedge ACLK); #2;
            n++;
        end
        if (n >= 3000) begin
            checks++; failures++;
            $display("FAIL timeout_%s actual=still_busy required=idle", name);
        end
        repeat (2) @(posedge ACLK);
    endtask

    task automatic apply_reset();
        @(posedge ACLK); #3;
        ARESETN = 1'b0;
        repeat (2) @(posedge ACLK);
        #3 ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    initial begin
        int base;
        repeat (3) @(posedge ACLK);
        #1 check("reset_busy_ack", {busy, ack}, 3'b000);
        #2 ARESETN = 1'b1;

        // Write then read back through client 0, zero-wait slave.
        base = alog_cli.size();
        push(0, 1, 32'h0, 32'h0101FFFF);
        wait_done("t1_write");
        check("t1_write_latency", alog_cyc[base] - req_cyc[0], 3);
        check("t1_write_resp", alog_resp[base], 2'b00);
        push(0, 0, 32'h0, 32'h0);
        wait_done("t1_read");
        check("t1_read_latency", alog_cyc[base+1] - req_cyc[0], 3);
        check("t1_read_rdata", alog_rdata[base+1], 32'h0101FFFF);
        check("t1_read_resp", alog_resp[base+1], 2'b00);

        // Simultaneous requests after reset: client 0 first.
        apply_reset();
        base = alog_cli.size();
        push(0, 1, 32'h4, 32'hABCD0001);
        push(1, 0, 32'h4, 32'h0);
        wait_done("t2");
        check("t2_first_client", alog_cli[base], 0);
        check("t2_second_client", alog_cli[base+1], 1);
        check("t2_read_data", alog_rdata[base+1], 32'hABCD0001);

        // Continuous contention alternates.
        base = alog_cli.size();
        @(negedge ACLK);
        push(0, 1, 32'h8, 32'h11111111); push(0, 0, 32'h8, 32'h0);
        push(1, 1, 32'hC, 32'h22222222); push(1, 0, 32'hC, 32'h0);
        wait_done("t3");
        check("t3_ack_count", alog_cli.size() - base, 4);
        for (int k = 0; k < 4; k++) check($sformatf("t3_grant%0d", k), alog_cli[base+k], k % 2);
        check("t3_read0", alog_rdata[base+2], 32'h11111111);
        check("t3_read1", alog_rdata[base+3], 32'h22222222);

        // AWREADY three cycles late, WREADY immediate.
        aw_dly = 3; awv_cnt = 0; wv_cnt = 0;
        base = alog_cli.size();
        push(1, 1, 32'h10, 32'hDEAD0011);
        wait_done("t4_write");
        check("t4_awvalid_cycles", awv_cnt, 4);
        check("t4_wvalid_cycles", wv_cnt, 1);
        aw_dly = 0;
        push(1, 0, 32'h10, 32'h0);
        wait_done("t4_read");
        check("t4_read_data", alog_rdata[base+1], 32'hDEAD0011);

        // Slave error responses.
        s_err = 1;
        base = alog_cli.size();
        push(0, 1, 32'h14, 32'h55555555);
        push(0, 0, 32'h14, 32'h0);
        wait_done("t5");
        check("t5_write_resp", alog_resp[base], 2'b10);
        check("t5_read_resp", alog_resp[base+1], 2'b10);
        check("t5_read_data", alog_rdata[base+1], 32'h0);
        s_err = 0;

        // Reset while waiting for R: client 0 was last granted, then reset restores client-0 priority.
        r_hold = 1;
        push(0, 0, 32'h0, 32'h0);
        begin
            int n;
            n = 0;
            while (!RREADY && n < 50) begin @(negedge ACLK); n++; end
            if (n >= 50) begin checks++; failures++; $display("FAIL t6_reach_rd actual=no_rready required=rready"); end
        end
        base = alog_cli.size();
        @(posedge ACLK); #3;
        ARESETN = 1'b0;
        #1 check("t6_async_reset", {ARVALID, RREADY, busy, ack}, 5'b0);
        r_hold = 0;
        repeat (2) @(posedge ACLK);
        #3 ARESETN = 1'b1;
        check("t6_no_ack", alog_cli.size() - base, 0);
        @(negedge ACLK);
        push(0, 1, 32'h18, 32'h18181818);
        push(1, 1, 32'h1C, 32'h1C1C1C1C);
        wait_done("t6");
        check("t6_first_after_reset", alog_cli[base], 0);

        // Randomized batches.
        gap_en = 1;
        for (int b = 0; b < 4; b++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            s_err = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 10; k++) begin
                push(0, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
                push(1, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
            end
            wait_done($sformatf("rand%0d", b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axil_master_arbiter.md
# axil_master_arbiter

Two-requester AXI4-Lite master that shares a single AXI4-Lite slave register bank (the AXI_inout register file) between two on-fabric clients, e.g. the lock-loop sequencer and a debug/scan engine. Each client issues simple single-beat register read/write requests. The block arbitrates round-robin, runs the full AXI4-Lite handshake, and returns read data and response to the granted client.

## Interface
Parameters:
- ADDR_W, 32, address width for clients and AXI
- DATA_W, 32, data width; WSTRB is all-ones, DATA_W/8 bits

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous, active-low reset
- req  in  2  per-client request level; bit i is client i
- we  in  2  1 = write, 0 = read
- addr  in  2*ADDR_W  client i uses bits [i*ADDR_W +: ADDR_W]
- wdata  in  2*DATA_W  client i uses bits [i*DATA_W +: DATA_W]
- ack  out  2  one-cycle completion pulse to the granted client
- rdata  out  DATA_W  read data; valid only while ack is high
- resp  out  2  AXI response (OKAY/SLVERR/DECERR); valid only while ack is high
- busy  out  1  high from grant through ack
- M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in
- M_AXI_WDATA/WSTRB/WVALID out, WREADY in
- M_AXI_BRESP/BVALID in, BREADY out
- M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in
- M_AXI_RDATA/RRESP/RVALID in, RREADY out

## Operation
- States: IDLE, WR (AW+W issued), WB (wait B), RA (AR issued), RD (wait R), DONE.
- IDLE: if any req is high, grant one client and latch its we/addr/wdata. Go to WR if we = 1, else RA.
- Arbitration is round-robin on the last-granted pointer:
  - Pointer resets to 1, so client 0 wins the first contention.
  - With a single requester, that requester wins regardless of the pointer.
- WR: AWVALID and WVALID assert together. Each one drops independently on its own handshake. When both channels have completed (in the same or different cycles), go to WB.
- WB: BREADY = 1. On BVALID, capture BRESP, go to DONE.
- RA: ARVALID = 1 until ARREADY, then RD.
- RD: RREADY = 1. On RVALID, capture RDATA/RRESP, go to DONE.
- DONE: ack[grant] = 1, rdata/resp driven from the capture registers, then go to IDLE.
  - The acked client's req is ignored in the DONE cycle.
  - A req still high in the following IDLE cycle is a new transaction.
- Client contract: hold req/we/addr/wdata stable until ack. The block latches them at grant anyway.
- AWPROT/ARPROT = 3'b000. WSTRB = all ones. For write transactions, rdata = 0.
- Valid signals never drop before their handshake completes (AXI rule). No timeout: a hung slave holds busy high.

## Timing
- All AXI outputs, ack, rdata, resp and busy are registered.
- Reset values: all VALID/READY outputs 0, ack 0, busy 0, addresses/data/resp 0, state IDLE.
- Write latency with a zero-wait slave (AWREADY = WREADY = 1, BVALID one cycle after the W handshake):
  - req high at cycle 0
  - AW/W valid at cycle 1
  - B handshake at cycle 2
  - ack at cycle 3
- Read latency with a zero-wait slave: ARVALID at cycle 1, R handshake at cycle 2, ack at cycle 3.
- Minimum spacing between consecutive grants: one IDLE cycle after DONE.
- Reset mid-transaction: everything returns to reset values immediately. No ack is issued for the aborted transaction, and the round-robin pointer resets.

## Structure
- Shared package axil_pkg holds:
  - state enum
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - PROT_DEFAULT constant
- Sub-module rr_arbiter2: round-robin 2-way, with inputs req[1:0] and update, outputs grant_idx and grant_valid, and the pointer register inside.
- The rest of the logic is a single FSM in axil_master_arbiter.

## Test plan
- Client 0 writes 0x0101FFFF to 0x0 then reads it back; zero-wait slave -> each ack arrives at cycle 3, rdata = 0x0101FFFF, resp = 00.
- Both clients request in the same cycle after reset (client 0 writes 0xABCD0001 @0x4, client 1 reads @0x4) -> client 0 is served first; client 1 then reads 0xABCD0001.
- Both clients hold req continuously for 4 transactions -> grants alternate 0, 1, 0, 1, each with exactly one ack pulse.
- Slave with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles, write 0xDEAD0011 completes correctly.
- Slave returns BRESP/RRESP = 2'b10 -> resp = 10 on ack, and no further AXI activity for that request.
- ARESETN asserted while in RD with RVALID low -> ARVALID/RREADY/busy are 0 immediately, no ack; after release, client 0 is granted first.
